ray_dir_gen: RTL and testbench
==============================

// Module: ray_dir_gen
// PURPOSE
//  Per-pixel ray-direction generator; sits directly downstream of viewport_params.
//  - On frame_start, latches the viewport origin and the u/v basis vectors.
//  - Walks the screen in raster order, one ray per valid/ready handshake.
//  - Computes each direction incrementally (adds only, no multipliers, no divider).
//  - Feeds the ray marcher. Direction magnitude is unnormalised; the marcher is scale-invariant.
// PARAMETERS
//  H_DISP    1280  pixels per row
//  V_DISP    720   rows per frame
//  VP_SCALE  225   fixed-point unit of the viewport vectors; origin is pre-multiplied by it
//  ACC_W     32    signed accumulator / output width per axis
// PORTS
//  clk                       in   1      single clock
//  rst_n                     in   1      synchronous reset, active-low
//  frame_start               in   1      1-cycle pulse: latch params, begin frame
//  vp_origin_x/y/z           in   16 s   top-left viewport corner
//  vp_u_x/y/z                in   16 s   screen-right basis vector
//  vp_v_x/y/z                in   16 s   screen-up basis vector
//  ray_valid                 out  1      ray fields valid
//  ray_ready                 in   1      downstream accepts when ray_valid&ray_ready
//  ray_dir_x/y/z             out  ACC_W s  ray direction
//  ray_px                    out  11     pixel column
//  ray_py                    out  10     pixel row
//  ray_sol/ray_eol/ray_eof   out  1      start-of-line / end-of-line / last pixel of frame
//  frame_busy                out  1      high in RUN
//  frame_done                out  1      1-cycle pulse on acceptance of the eof ray
// BEHAVIOUR
//  Direction definition:
//  - dir(px,py) = origin*VP_SCALE + 2*px*u - 2*py*v, computed per axis, sign-extended to ACC_W.
//  Reset (rst_n=0 at a clock edge):
//  - State -> IDLE. All outputs 0. Latched params 0.
//  - Applies mid-frame with no flush; the next frame requires a new frame_start.
//  FSM IDLE -> RUN:
//  - Taken on frame_start.
//  - Latches u2=2*u and v2=2*v.
//  - Sets row_acc = pix_acc = origin*VP_SCALE, px=0, py=0.
//  - ray_valid rises the cycle after frame_start (latency 1).
//  In RUN, on each handshake:
//  - If px<H_DISP-1: px++, pix_acc += u2.
//  - Else (end of row): px=0, py++, row_acc -= v2, pix_acc = row_acc - v2.
//  Leaving RUN:
//  - On handshake with eof (px=H_DISP-1, py=V_DISP-1): frame_done=1 for that one cycle.
//  - Next state is IDLE, unless frame_start is high in that same cycle.
//  - With frame_start in that cycle: reload params and stay in RUN (back-to-back, zero bubble).
//  Backpressure:
//  - While ray_valid & !ray_ready, all ray_* outputs hold stable.
//  - ray_valid never drops without a handshake.
//  frame_start in RUN, other than in the eof-handshake cycle, is ignored (params are not re-latched).
//  Flags:
//  - ray_sol = (px==0). ray_eol = (px==H_DISP-1). ray_eof = ray_eol & (py==V_DISP-1).
//  - All flags are registered alongside the ray.
//  Arithmetic:
//  - Two's complement, wrap on overflow; no saturation.
//  - ACC_W=32 covers |dir| < 2^31 for the default H/V and 16-bit inputs.
//  Parameter updates while in RUN do not affect the frame in progress.
// STRUCTURE
//  viewport_defs.vh (shared include):
//  - ACC_W and VP_SCALE defaults.
//  - FSM encodings ST_IDLE=1'b0, ST_RUN=1'b1.
//  - Pixel counter widths (11/10).
//  Sub-module ray_axis_acc, instantiated 3x (x/y/z):
//  - Holds one axis's latched u2/v2, row_acc and pix_acc.
//  - Controls: load, step_px, step_row.
//  The top level owns the FSM, px/py counters, flags and the handshake.
// TESTING  (H_DISP=4, V_DISP=3 unless noted)
//  1. origin=(100,-50,20), u=(225,0,0), v=(0,0,225), ready=1, frame_start pulse
//     -> valid next cycle, dir(0,0)=(22500,-11250,4500), dir(1,0).x=22950, dir(0,1).z=4050,
//        exactly 12 handshakes, eof on (3,2), one frame_done.
//  2. Toggle ready pseudo-randomly -> rays identical to test 1; outputs stable across every stall.
//  3. Change vp_* inputs and pulse frame_start mid-frame
//     -> no effect; frame completes with the original params.
//  4. frame_start asserted in the eof-handshake cycle -> (0,0) of the new frame appears next cycle, no gap.
//  5. rst_n=0 for 1 cycle at pixel (2,1) -> all outputs 0, state IDLE; clean frame after next frame_start.
//  6. Default 1280x720 with u=(-225,0,0), v=(0,-225,0)
//     -> dir(1279,719) matches the reference model; no overflow.

Source files
------------

// File: rtl/ray_dir_gen_pkg.sv
// Shared types and constants for the ray direction generator.
// Origin scaling is shift-add so the datapath stays multiplier-free.
package ray_dir_gen_pkg;

  localparam int ACC_W = 32;
  localparam int PX_W  = 11;
  localparam int PY_W  = 10;
  localparam logic [15:0] VP_SCALE = 16'd225;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic acc_t scale_origin(
    input logic signed [15:0] o
  );
    acc_t e;
    acc_t r;
    e = acc_t'(o);
    r = '0;
    for (int i = 0; i < 16; i++)
      if (VP_SCALE[i]) r = r + (e <<< i);
    return r;
  endfunction

endpackage

// File: rtl/ray_dir_gen_if.sv
// Ray output stream: valid/ready handshake plus
// direction, pixel coordinates and raster flags.
interface ray_dir_gen_if
  import ray_dir_gen_pkg::*;
;
  logic            ray_valid;
  logic            ray_ready;
  acc_t            ray_dir_x;
  acc_t            ray_dir_y;
  acc_t            ray_dir_z;
  logic [PX_W-1:0] ray_px;
  logic [PY_W-1:0] ray_py;
  logic            ray_sol;
  logic            ray_eol;
  logic            ray_eof;

  modport master (
    output ray_valid, ray_dir_x, ray_dir_y,
    output ray_dir_z, ray_px, ray_py,
    output ray_sol, ray_eol, ray_eof,
    input  ray_ready
  );

  modport slave (
    input  ray_valid, ray_dir_x, ray_dir_y,
    input  ray_dir_z, ray_px, ray_py,
    input  ray_sol, ray_eol, ray_eof,
    output ray_ready
  );

endinterface

// File: rtl/ray_dir_gen_axis_acc.sv
// One axis of the incremental direction datapath:
// latched 2u/2v steps, row start and current pixel accumulators.
module ray_axis_acc
  import ray_dir_gen_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step_px,
  input  logic               step_row,
  input  logic signed [15:0] origin_i,
  input  logic signed [15:0] u_i,
  input  logic signed [15:0] v_i,
  output acc_t               dir_o
);

  acc_t u2_q, u2_d;
  acc_t v2_q, v2_d;
  acc_t row_q, row_d;
  acc_t pix_q, pix_d;

  always_comb begin
    u2_d  = u2_q;
    v2_d  = v2_q;
    row_d = row_q;
    pix_d = pix_q;
    unique case (1'b1)
      load: begin
        u2_d  = acc_t'(u_i) <<< 1;
        v2_d  = acc_t'(v_i) <<< 1;
        row_d = scale_origin(origin_i);
        pix_d = scale_origin(origin_i);
      end
      step_row: begin
        row_d = row_q - v2_q;
        pix_d = row_q - v2_q;
      end
      step_px: pix_d = pix_q + u2_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      u2_q  <= '0;
      v2_q  <= '0;
      row_q <= '0;
      pix_q <= '0;
    end else begin
      u2_q  <= u2_d;
      v2_q  <= v2_d;
      row_q <= row_d;
      pix_q <= pix_d;
    end
  end

  assign dir_o = pix_q;

endmodule

// File: rtl/ray_dir_gen.sv
// Raster-order ray direction generator: FSM, pixel
// counters, flags and handshake; three axis accumulators.
module ray_dir_gen
  import ray_dir_gen_pkg::*;
#(
  parameter int H_DISP = 1280,
  parameter int V_DISP = 720
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic signed [15:0] vp_origin_x,
  input  logic signed [15:0] vp_origin_y,
  input  logic signed [15:0] vp_origin_z,
  input  logic signed [15:0] vp_u_x,
  input  logic signed [15:0] vp_u_y,
  input  logic signed [15:0] vp_u_z,
  input  logic signed [15:0] vp_v_x,
  input  logic signed [15:0] vp_v_y,
  input  logic signed [15:0] vp_v_z,
  ray_dir_gen_if.master      ray,
  output logic               frame_busy,
  output logic               frame_done
);

  localparam logic [PX_W-1:0] PX_LAST =
    PX_W'(H_DISP - 1);
  localparam logic [PY_W-1:0] PY_LAST =
    PY_W'(V_DISP - 1);

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic [PX_W-1:0] px_q, px_d;
  logic [PY_W-1:0] py_q, py_d;
  logic            sol_q, eol_q, eof_q;

  logic hs, eof_hs, load;
  logic step_px, step_row;

  assign hs       = valid_q & ray.ray_ready;
  assign eof_hs   = hs & eof_q;
  // Reload is legal only from IDLE or on the eof handshake.
  assign load     = frame_start &
                    ((state_q == ST_IDLE) | eof_hs);
  assign step_px  = hs & ~eol_q;
  assign step_row = hs & eol_q & ~eof_q;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    px_d    = px_q;
    py_d    = py_q;
    unique case (1'b1)
      load: begin
        state_d = ST_RUN;
        valid_d = 1'b1;
        px_d    = '0;
        py_d    = '0;
      end
      eof_hs & ~frame_start: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        px_d    = '0;
        py_d    = '0;
      end
      step_row: begin
        px_d = '0;
        py_d = py_q + 1'b1;
      end
      step_px: px_d = px_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      sol_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      px_q    <= px_d;
      py_q    <= py_d;
      sol_q   <= valid_d & (px_d == '0);
      eol_q   <= valid_d & (px_d == PX_LAST);
      eof_q   <= valid_d & (px_d == PX_LAST) &
                 (py_d == PY_LAST);
    end
  end

  ray_axis_acc u_ax (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step_px  (step_px),
    .step_row (step_row),
    .origin_i (vp_origin_x),
    .u_i      (vp_u_x),
    .v_i      (vp_v_x),
    .dir_o    (ray.ray_dir_x)
  );

  ray_axis_acc u_ay (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step_px  (step_px),
    .step_row (step_row),
    .origin_i (vp_origin_y),
    .u_i      (vp_u_y),
    .v_i      (vp_v_y),
    .dir_o    (ray.ray_dir_y)
  );

  ray_axis_acc u_az (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step_px  (step_px),
    .step_row (step_row),
    .origin_i (vp_origin_z),
    .u_i      (vp_u_z),
    .v_i      (vp_v_z),
    .dir_o    (ray.ray_dir_z)
  );

  assign ray.ray_valid = valid_q;
  assign ray.ray_px    = px_q;
  assign ray.ray_py    = py_q;
  assign ray.ray_sol   = sol_q;
  assign ray.ray_eol   = eol_q;
  assign ray.ray_eof   = eof_q;
  assign frame_busy    = (state_q == ST_RUN);
  assign frame_done    = eof_hs;

endmodule

// File: tb/tb_ray_dir_gen.sv
// Directed bench: 4x3 instance for frame behaviour,
// default-size instance for the first rows of a large frame.
module tb_ray_dir_gen;

  localparam int SH = 4;
  localparam int SV = 3;
  localparam int BH = 1280;
  localparam int BROWS = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic fs, bfs;
  logic signed [15:0] vo [3];
  logic signed [15:0] vu [3];
  logic signed [15:0] vv [3];
  logic signed [15:0] bo [3];
  logic signed [15:0] bu [3];
  logic signed [15:0] bv [3];
  logic busy, done, bbusy, bdone;
  int eo [3];
  int eu [3];
  int ev [3];
  int errors = 0;
  int checks = 0;

  ray_dir_gen_if rif ();
  ray_dir_gen_if rif2 ();

  always #5 clk = ~clk;

  ray_dir_gen #(.H_DISP(SH), .V_DISP(SV)) u_dut (
    .clk(clk), .rst_n(rst_n), .frame_start(fs),
    .vp_origin_x(vo[0]), .vp_origin_y(vo[1]),
    .vp_origin_z(vo[2]),
    .vp_u_x(vu[0]), .vp_u_y(vu[1]), .vp_u_z(vu[2]),
    .vp_v_x(vv[0]), .vp_v_y(vv[1]), .vp_v_z(vv[2]),
    .ray(rif), .frame_busy(busy), .frame_done(done)
  );

  ray_dir_gen u_big (
    .clk(clk), .rst_n(rst_n), .frame_start(bfs),
    .vp_origin_x(bo[0]), .vp_origin_y(bo[1]),
    .vp_origin_z(bo[2]),
    .vp_u_x(bu[0]), .vp_u_y(bu[1]), .vp_u_z(bu[2]),
    .vp_v_x(bv[0]), .vp_v_y(bv[1]), .vp_v_z(bv[2]),
    .ray(rif2), .frame_busy(bbusy), .frame_done(bdone)
  );

  function automatic logic signed [31:0] model(
    int o, int u, int v, int px, int py
  );
    longint r;
    r = longint'(o) * 225 + 2 * longint'(px) * u
        - 2 * longint'(py) * v;
    return r[31:0];
  endfunction

  function automatic logic [119:0] snap_now();
    return {rif.ray_dir_x, rif.ray_dir_y,
            rif.ray_dir_z, rif.ray_px, rif.ray_py,
            rif.ray_sol, rif.ray_eol, rif.ray_eof};
  endfunction

  task automatic set_params();
    vo = '{16'sd100, -16'sd50, 16'sd20};
    vu = '{16'sd225, 16'sd0, 16'sd0};
    vv = '{16'sd0, 16'sd0, 16'sd225};
    for (int i = 0; i < 3; i++) begin
      eo[i] = int'(vo[i]);
      eu[i] = int'(vu[i]);
      ev[i] = int'(vv[i]);
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
  endtask

  // Walks one 4x3 frame from the current (already valid) ray.
  task automatic walk_frame(
    input bit rnd, input bit poke, input bit chain
  );
    int epx, epy, nhs, ndn;
    bit fin, stl;
    logic [119:0] saved, now;
    logic signed [31:0] e;
    logic [24:0] epos, apos;
    epx = 0; epy = 0; nhs = 0; ndn = 0;
    fin = 1'b0; stl = 1'b0; saved = '0;
    for (int c = 0; c < 400 && !fin; c++) begin
      rif.ray_ready = rnd ?
        1'($urandom_range(0, 1)) : 1'b1;
      if (poke && nhs == 5) begin
        vo[0] = 16'sd7; vu[0] = 16'sd1;
        vv[2] = 16'sd3; fs = 1'b1;
      end
      if (chain && rif.ray_valid && rif.ray_eof)
        fs = 1'b1;
      #1;
      now = snap_now();
      if (stl) begin
        checks++;
        if (now !== saved) begin
          errors++;
          $display("FAIL stall_hold got=%h exp=%h",
                   now, saved);
        end
      end
      if (!rif.ray_valid) begin
        checks++; errors++;
        $display("FAIL valid_drop at px=%0d py=%0d",
                 epx, epy);
        fin = 1'b1;
      end else if (rif.ray_ready) begin
        for (int a = 0; a < 3; a++) begin
          e = model(eo[a], eu[a], ev[a], epx, epy);
          now = snap_now();
          checks++;
          if (now[119-32*a -: 32] !== e) begin
            errors++;
            $display("FAIL dir%0d (%0d,%0d) got=%0d exp=%0d",
                     a, epx, epy,
                     $signed(now[119-32*a -: 32]), e);
          end
        end
        epos = {11'(epx), 10'(epy), epx == 0,
                epx == SH-1, epx == SH-1 && epy == SV-1,
                1'b1, epx == SH-1 && epy == SV-1};
        apos = {rif.ray_px, rif.ray_py, rif.ray_sol,
                rif.ray_eol, rif.ray_eof, busy, done};
        checks++;
        if (apos !== epos) begin
          errors++;
          $display("FAIL pos_flags got=%h exp=%h",
                   apos, epos);
        end
        nhs++;
        if (done) ndn++;
        if (epx == SH-1 && epy == SV-1) fin = 1'b1;
        if (epx == SH-1) begin
          epx = 0; epy++;
        end else epx++;
        stl = 1'b0;
      end else begin
        stl = 1'b1;
        saved = snap_now();
      end
      @(negedge clk);
      fs = 1'b0;
    end
    checks++;
    if (nhs != SH*SV) begin
      errors++;
      $display("FAIL hs_count got=%0d exp=%0d",
               nhs, SH*SV);
    end
    checks++;
    if (ndn != 1) begin
      errors++;
      $display("FAIL done_count got=%0d exp=1", ndn);
    end
  endtask

  task automatic check_idle(input string nm);
    #1;
    checks++;
    if ({rif.ray_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL %s_idle got=%b exp=000", nm,
               {rif.ray_valid, busy, done});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fs = 1'b0; bfs = 1'b0;
    rif.ray_ready = 1'b0; rif2.ray_ready = 1'b0;
    set_params();
    bo = '{16'sd32767, -16'sd32768, 16'sd100};
    bu = '{-16'sd225, 16'sd0, 16'sd0};
    bv = '{16'sd0, -16'sd225, 16'sd0};
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({snap_now(), rif.ray_valid, busy, done}
        !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0",
               snap_now());
    end
    checks++;
    if ({rif2.ray_valid, rif2.ray_dir_x, bbusy}
        !== '0) begin
      errors++;
      $display("FAIL reset_big got=%b exp=0",
               rif2.ray_valid);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_frame();
    check_idle("pre_start");
    start_frame();
    #1;
    checks++;
    if (!rif.ray_valid) begin
      errors++;
      $display("FAIL latency valid=%b exp=1",
               rif.ray_valid);
    end
    checks++;
    if ({rif.ray_dir_x, rif.ray_dir_y, rif.ray_dir_z}
        !== {32'sd22500, -32'sd11250, 32'sd4500}) begin
      errors++;
      $display("FAIL dir00 got=%0d,%0d,%0d exp=22500,-11250,4500",
               rif.ray_dir_x, rif.ray_dir_y,
               rif.ray_dir_z);
    end
    rif.ray_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rif.ray_dir_x !== 32'sd22950) begin
      errors++;
      $display("FAIL dir10x got=%0d exp=22950",
               rif.ray_dir_x);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rif.ray_dir_z !== 32'sd4050) begin
      errors++;
      $display("FAIL dir01z got=%0d exp=4050",
               rif.ray_dir_z);
    end
    rif.ray_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_frame();
    walk_frame(1'b0, 1'b0, 1'b0);
    check_idle("post_frame");
  endtask

  task automatic test_backpressure();
    start_frame();
    walk_frame(1'b1, 1'b0, 1'b0);
    check_idle("post_stall");
  endtask

  task automatic test_mid_restart();
    start_frame();
    walk_frame(1'b0, 1'b1, 1'b0);
    check_idle("post_poke");
    set_params();
  endtask

  task automatic test_back_to_back();
    start_frame();
    walk_frame(1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if ({rif.ray_valid, rif.ray_px, rif.ray_py,
         rif.ray_dir_x}
        !== {1'b1, 11'd0, 10'd0, 32'sd22500}) begin
      errors++;
      $display("FAIL b2b_first v=%b px=%0d py=%0d x=%0d",
               rif.ray_valid, rif.ray_px, rif.ray_py,
               rif.ray_dir_x);
    end
    walk_frame(1'b0, 1'b0, 1'b0);
    check_idle("post_b2b");
  endtask

  task automatic test_mid_reset();
    bit hit;
    hit = 1'b0;
    start_frame();
    for (int c = 0; c < 20 && !hit; c++) begin
      rif.ray_ready = 1'b1;
      #1;
      if (rif.ray_px == 11'd2 && rif.ray_py == 10'd1)
        hit = 1'b1;
      else
        @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reach_2_1 px=%0d py=%0d exp=2,1",
               rif.ray_px, rif.ray_py);
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({snap_now(), rif.ray_valid, busy, done}
        !== '0) begin
      errors++;
      $display("FAIL mid_reset got=%h exp=0",
               snap_now());
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_reset");
    start_frame();
    walk_frame(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_default_size();
    int n, epx, epy;
    logic [95:0] e, g;
    n = 0; epx = 0; epy = 0;
    rif2.ray_ready = 1'b1;
    @(negedge clk);
    bfs = 1'b1;
    @(negedge clk);
    bfs = 1'b0;
    for (int c = 0; c < 26000 && n < BH*BROWS; c++) begin
      #1;
      if (rif2.ray_valid) begin
        e = {model(32767, -225, 0, epx, epy),
             model(-32768, 0, -225, epx, epy),
             model(100, 0, 0, epx, epy)};
        g = {rif2.ray_dir_x, rif2.ray_dir_y,
             rif2.ray_dir_z};
        checks++;
        if (g !== e || rif2.ray_px !== 11'(epx) ||
            rif2.ray_py !== 10'(epy)) begin
          errors++;
          $display("FAIL big (%0d,%0d) got=%h exp=%h",
                   epx, epy, g, e);
        end
        n++;
        if (epx == BH-1) begin
          epx = 0; epy++;
        end else epx++;
      end
      @(negedge clk);
    end
    checks++;
    if (n != BH*BROWS) begin
      errors++;
      $display("FAIL big_count got=%0d exp=%0d",
               n, BH*BROWS);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_mid_restart();
    test_back_to_back();
    test_mid_reset();
    test_default_size();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
